// File: rtl/slice_serializer.sv
// Wide-word to slice serializer with valid/ready handshakes on both sides.
// Define SLICE_SERIALIZER_MSB_FIRST_EN to emit slices from highest index down to 0.
module slice_serializer #(
  parameter int SLICE_WIDTH      = 8,
  parameter int SELECT_BUS_WIDTH = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [(SLICE_WIDTH<<SELECT_BUS_WIDTH)-1:0] in_data,
  input  logic [((SELECT_BUS_WIDTH > 0) ? SELECT_BUS_WIDTH : 1)-1:0] in_len,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [SLICE_WIDTH-1:0]                 out_data,
  output logic                                   out_last
);

  localparam int LW = (SELECT_BUS_WIDTH > 0) ? SELECT_BUS_WIDTH : 1;
  localparam int DW = SLICE_WIDTH << SELECT_BUS_WIDTH;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state;
  logic [DW-1:0]   data;
  logic [LW-1:0]   idx;
  logic [LW-1:0]   len;
  logic [LW-1:0]   len_in;
  logic [LW-1:0]   start_idx;
  logic [LW-1:0]   end_idx;
  logic [LW-1:0]   next_idx;
  logic            accept;

  always_comb begin
    len_in = (SELECT_BUS_WIDTH == 0) ? '0 : in_len;
`ifdef SLICE_SERIALIZER_MSB_FIRST_EN
    start_idx = len_in;
    end_idx   = '0;
    next_idx  = idx - LW'(1);
`else
    start_idx = '0;
    end_idx   = len;
    next_idx  = idx + LW'(1);
`endif
  end

  assign out_valid = (state == SHIFT);
  assign out_last  = (state == SHIFT) && (idx == end_idx);
  assign out_data  = data[idx*SLICE_WIDTH +: SLICE_WIDTH];
  // Accept may coincide with the final beat so back-to-back words have no bubble.
  assign in_ready  = (state == IDLE) || (out_ready && out_last);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data  <= '0;
      idx   <= '0;
      len   <= '0;
    end else if (accept) begin
      state <= SHIFT;
      data  <= in_data;
      len   <= len_in;
      idx   <= start_idx;
    end else if (state == SHIFT && out_ready) begin
      if (out_last) state <= IDLE;
      else          idx   <= next_idx;
    end
  end

endmodule

// File: tb/tb_slice_serializer.sv
// Self-checking bench for slice_serializer: vector tables, directed corner cases,
// and randomized traffic against a queue-based reference model.
module tb_slice_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [2:0]  in_len = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_last;

  logic        s0_in_valid = 1'b0;
  logic        s0_in_ready;
  logic [7:0]  s0_in_data = '0;
  logic [0:0]  s0_in_len = '0;
  logic        s0_out_valid;
  logic        s0_out_ready = 1'b0;
  logic [7:0]  s0_out_data;
  logic        s0_out_last;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  localparam logic [63:0] W = 64'h0123_4567_89ab_cdef;
  localparam logic [63:0] B = 64'h0000_0123_4567_89ab;

  always #5 clk = ~clk;

  slice_serializer #(.SLICE_WIDTH(8), .SELECT_BUS_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_len(in_len), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  slice_serializer #(.SLICE_WIDTH(8), .SELECT_BUS_WIDTH(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(s0_in_valid), .in_ready(s0_in_ready),
    .in_data(s0_in_data), .in_len(s0_in_len), .out_valid(s0_out_valid),
    .out_ready(s0_out_ready), .out_data(s0_out_data), .out_last(s0_out_last)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // k-th emitted slice of a word with the given length-minus-one.
  function automatic logic [7:0] exp_slice(input logic [63:0] d, input int unsigned len,
                                           input int unsigned k);
    int unsigned pos;
`ifdef SLICE_SERIALIZER_MSB_FIRST_EN
    pos = len - k;
`else
    pos = k;
`endif
    return d[8*pos +: 8];
  endfunction

  // Reference model: queue of slices still owed for the current word.
  logic [7:0] q[$];

  always @(posedge clk) begin
    bit m_ready;
    m_ready = (q.size() == 0) || (out_ready && q.size() == 1);
    if (rst) q.delete();
    else begin
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (in_valid && m_ready)
        for (int unsigned k = 0; k <= in_len; k++) q.push_back(exp_slice(in_data, in_len, k));
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_out_valid", out_valid, q.size() != 0);
      chk("mon_out_last", out_last, q.size() == 1);
      chk("mon_in_ready", in_ready, (q.size() == 0) || (out_ready && q.size() == 1));
      if (q.size() != 0) chk("mon_out_data", out_data, q[0]);
    end
  end

  typedef struct packed {
    logic       iv;
    logic [2:0] il;
    logic [63:0] id;
    logic       ordy;
    logic       ev;
    logic [7:0] ed;
    logic       el;
    logic       er;
    logic       cd;
  } vec_t;

  vec_t tbl[$];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int beats;
    bit stalled_prev;
    logic [7:0] prevd;
    logic [7:0] d0[6];

`ifdef SLICE_SERIALIZER_MSB_FIRST_EN
    tbl.push_back('{1'b1, 3'd2, W, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 3'd0, W, 1'b1, 1'b1, 8'hab, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 3'd0, W, 1'b1, 1'b1, 8'hcd, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 3'd0, W, 1'b1, 1'b1, 8'hef, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 3'd0, W, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
`else
    tbl.push_back('{1'b1, 3'd7, W, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 3'd0, W, 1'b1, 1'b1, 8'hef, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 3'd0, W, 1'b1, 1'b1, 8'hcd, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 3'd0, W, 1'b1, 1'b1, 8'hab, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 3'd0, W, 1'b1, 1'b1, 8'h89, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 3'd0, W, 1'b1, 1'b1, 8'h67, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 3'd0, W, 1'b1, 1'b1, 8'h45, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 3'd0, W, 1'b1, 1'b1, 8'h23, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 3'd0, W, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 3'd0, W, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
`endif

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Table vectors; first row also checks the post-reset output state.
    foreach (tbl[i]) begin
      in_valid = tbl[i].iv; in_len = tbl[i].il; in_data = tbl[i].id; out_ready = tbl[i].ordy;
      @(negedge clk);
      chk("tbl_out_valid", out_valid, tbl[i].ev);
      chk("tbl_out_last", out_last, tbl[i].el);
      chk("tbl_in_ready", in_ready, tbl[i].er);
      if (tbl[i].cd) chk("tbl_out_data", out_data, tbl[i].ed);
      next_cycle();
    end

    // Backpressure: out_ready pattern 1,0,0,1,0,0,...
    in_valid = 1'b1; in_len = 3'd7; in_data = W; out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    beats = 0; stalled_prev = 1'b0; prevd = '0;
    for (int c = 0; c < 40 && beats < 8; c++) begin
      out_ready = (c % 3 == 0);
      @(negedge clk);
      if (stalled_prev) chk("bp_hold", out_data, prevd);
      if (out_valid && out_ready) begin
        chk("bp_data", out_data, exp_slice(W, 7, beats));
        beats++;
      end
      stalled_prev = out_valid && !out_ready;
      prevd = out_data;
      next_cycle();
    end
    chk("bp_beats", beats, 8);
    out_ready = 1'b1;
    next_cycle();

    // Back-to-back words with no bubble.
    in_valid = 1'b1; in_len = 3'd1; in_data = W;
    next_cycle();
    in_len = 3'd2; in_data = B;
    for (int c = 1; c <= 5; c++) begin
      logic [7:0] e;
      if (c == 3) in_valid = 1'b0;
      e = (c <= 2) ? exp_slice(W, 1, c - 1) : exp_slice(B, 2, c - 3);
      @(negedge clk);
      chk("b2b_valid", out_valid, 1'b1);
      chk("b2b_data", out_data, e);
      chk("b2b_last", out_last, (c == 2) || (c == 5));
      if (c == 2) chk("b2b_in_ready", in_ready, 1'b1);
      next_cycle();
    end
    @(negedge clk);
    chk("b2b_idle", out_valid, 1'b0);
    next_cycle();

    // Reset after the third beat; a simultaneous offer must be ignored.
    in_valid = 1'b1; in_len = 3'd7; in_data = W;
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1; in_valid = 1'b1;
    next_cycle();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_in_ready", in_ready, 1'b1);
    next_cycle();
    in_valid = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_restart_valid", out_valid, 1'b1);
    chk("rst_restart_data", out_data, exp_slice(W, 7, 0));
    repeat (9) next_cycle();

    // Single-slice instance: a new word every cycle, in_len ignored.
    d0[0] = 8'h5a;
    for (int i = 1; i < 6; i++) d0[i] = 8'($urandom);
    s0_in_valid = 1'b1; s0_out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      s0_in_data = d0[c];
      s0_in_len = 1'($urandom);
      @(negedge clk);
      chk("s0_in_ready", s0_in_ready, 1'b1);
      chk("s0_out_valid", s0_out_valid, c != 0);
      if (c != 0) begin
        chk("s0_out_data", s0_out_data, d0[c-1]);
        chk("s0_out_last", s0_out_last, 1'b1);
      end
      next_cycle();
    end
    s0_in_valid = 1'b0;

    // Randomized traffic checked by the reference model.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_len    = 3'($urandom);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 49) == 0);
      next_cycle();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slice_serializer.md
# slice_serializer

Sequential successor to the combinational slice multiplexer. Accepts a wide word of up to 2^SELECT_BUS_WIDTH slices over a valid/ready handshake and emits its slices one per accepted output beat over a second valid/ready handshake. A per-word slice count is supported, and back-to-back words stream without bubbles. It sits between wide datapath stages and narrow byte/lane-oriented consumers.

## Interface
- SLICE_WIDTH, 8, bits per output slice; ≥1.
- SELECT_BUS_WIDTH, 3, log2 of the maximum slice count; 0 means a single slice (registered passthrough).
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  word offered.
- in_ready  output  1  word accepted when in_valid && in_ready at a rising edge.
- in_data  input  SLICE_WIDTH<<SELECT_BUS_WIDTH  slice k occupies bits [k*SLICE_WIDTH +: SLICE_WIDTH].
- in_len  input  max(SELECT_BUS_WIDTH,1)  number of slices to emit, minus 1; ignored (treated as 0) when SELECT_BUS_WIDTH=0.
- out_valid  output  1  slice available.
- out_ready  input  1  slice consumed when out_valid && out_ready at a rising edge.
- out_data  output  SLICE_WIDTH  current slice.
- out_last  output  1  current slice is the final slice of its word.

## Operation
- State: busy flag (IDLE when 0, SHIFT when 1), data register, index counter idx, length register len.
- out_valid = busy; out_data = slice idx of the data register; out_last = busy && (idx == end index).
- in_ready = !busy || (out_ready && out_last). This is combinational from out_ready, so an accept can coincide with the final beat.
- Input accept: load data, load len, set idx to the start index, set busy=1.
- Output beat, not last: idx steps toward the end index; data and len are held.
- Output beat, last, no simultaneous accept: busy=0. idx, data and len are held and don't-care.
- Output beat, last, with simultaneous accept: the new word is loaded and busy stays 1. There is no bubble.
- in_data and in_len are sampled only at accept. They may change freely at other times.
- idx never exceeds len. Arithmetic is unsigned modulo 2^SELECT_BUS_WIDTH; no wrap occurs because the end index bounds the count.
- out_valid must not depend on out_ready. out_data and out_last are stable while out_valid && !out_ready.

## Timing
- Reset (rst=1 at an edge) forces busy=0, idx=0, len=0, data=0. Resulting outputs: out_valid=0, out_last=0, out_data=0, in_ready=1.
- Reset applied mid-word discards the remaining slices and takes priority over any handshake in the same cycle.
- Latency: a word accepted at edge N presents its first slice at out_valid in the cycle after edge N.
- A word of L=in_len+1 slices occupies exactly L output beats. The sustained rate with out_ready held at 1 is one slice per cycle across word boundaries.
- With out_ready=0, state is frozen and in_ready=0 while busy.

## Configuration
- Macro SLICE_SERIALIZER_MSB_FIRST_EN.
- Undefined (default): start index 0, idx increments, end index len. Slices are emitted 0,1,…,len (LSB-first).
- Defined: start index len, idx decrements, end index 0. Slices are emitted len,…,1,0 (MSB-first).
- The handshake and timing are identical in both modes.

## Test plan
- LSB-first, defaults, in_data=64'h0123_4567_89ab_cdef, in_len=7, out_ready=1:
  - out_data sequence ef,cd,ab,89,67,45,23,01 on consecutive cycles.
  - out_last only on 01.
  - in_ready=0 during beats 1–7.
- Backpressure: same word, out_ready toggling 1,0,0,1,…:
  - each slice is held stable while stalled.
  - the sequence is unchanged, with exactly 8 accepted beats.
- Back-to-back words:
  - Stimulus: word A (in_len=1, data …cdef), then word B (in_len=2, data …4567_89ab), with in_valid held and out_ready=1.
  - out_data is ef,cd,ab,89,67 with no idle cycle between cd and ab.
  - out_last is asserted on cd and on 67.
- With SLICE_SERIALIZER_MSB_FIRST_EN defined, in_len=2:
  - out_data sequence is ab,cd,ef.
  - out_last is on ef.
- SELECT_BUS_WIDTH=0, in_data=8'h5a:
  - one beat of out_data=5a with out_last=1.
  - with out_ready=1 and in_valid held, a new word is accepted every cycle.
- Reset mid-word: assert rst after the 3rd beat of the 8-slice word.
  - The next cycle shows out_valid=0, out_last=0, out_data=0, in_ready=1.
  - A fresh word then restarts at slice ef.
